// File: rtl/apb4_csb_bridge.sv
// apb4_csb_bridge: APB4 slave to NVDLA CSB master bridge with alignment/strobe checking,
// optional non-posted writes, a REQ/WAIT timeout and a saturating error counter.
module apb4_csb_bridge #(
    parameter int ADDR_W      = 32,
    parameter int CSB_ADDR_W  = 16,
    parameter bit NPOSTED_WR  = 1'b1,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                  csb_clk,
    input  logic                  csb_rstn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic [31:0]           pwdata,
    input  logic [3:0]            pstrb,
    output logic [31:0]           prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  csb2nvdla_valid,
    input  logic                  csb2nvdla_ready,
    output logic [CSB_ADDR_W-1:0] csb2nvdla_addr,
    output logic [31:0]           csb2nvdla_wdat,
    output logic                  csb2nvdla_write,
    output logic                  csb2nvdla_nposted,
    input  logic                  nvdla2csb_valid,
    input  logic [31:0]           nvdla2csb_data,
    input  logic                  nvdla2csb_wr_complete,
    output logic [7:0]            err_count
);
    localparam int TW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, ERR} state_t;

    state_t        state;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tnxt;
    logic          tmo;
    logic          bad_acc;
    logic [7:0]    err_inc;
    logic          unused;

    assign tnxt    = tcnt + TW'(1);
    assign tmo     = (TIMEOUT_CYC != 0) && (tnxt == TW'(TIMEOUT_CYC));
    assign bad_acc = (paddr[1:0] != 2'b00) || (pwrite && pstrb != 4'hF);
    assign err_inc = err_count + 8'(err_count != 8'hFF);
    assign unused  = ^paddr;

    always_ff @(posedge csb_clk or negedge csb_rstn) begin
        if (!csb_rstn) begin
            state             <= IDLE;
            tcnt              <= '0;
            prdata            <= '0;
            pready            <= 1'b0;
            pslverr           <= 1'b0;
            csb2nvdla_valid   <= 1'b0;
            csb2nvdla_addr    <= '0;
            csb2nvdla_wdat    <= '0;
            csb2nvdla_write   <= 1'b0;
            csb2nvdla_nposted <= 1'b0;
            err_count         <= '0;
        end else begin
            case (state)
                IDLE: if (psel && penable) begin
                    csb2nvdla_addr  <= paddr[CSB_ADDR_W+1:2];
                    csb2nvdla_wdat  <= pwdata;
                    csb2nvdla_write <= pwrite;
                    prdata          <= '0;
                    if (bad_acc) begin
                        state     <= ERR;
                        pready    <= 1'b1;
                        pslverr   <= 1'b1;
                        err_count <= err_inc;
                    end else begin
                        state             <= REQ;
                        csb2nvdla_valid   <= 1'b1;
                        csb2nvdla_nposted <= pwrite & NPOSTED_WR;
                        tcnt              <= '0;
                    end
                end
                REQ: begin
                    tcnt <= tnxt;
                    if (csb2nvdla_ready) begin
                        csb2nvdla_valid <= 1'b0;
                        state           <= (csb2nvdla_write && !NPOSTED_WR) ? RESP : WAIT;
                        pready          <= csb2nvdla_write && !NPOSTED_WR;
                    end else if (tmo) begin
                        csb2nvdla_valid <= 1'b0;
                        state           <= ERR;
                        pready          <= 1'b1;
                        pslverr         <= 1'b1;
                        err_count       <= err_inc;
                    end
                end
                WAIT: begin
                    tcnt <= tnxt;
                    // a response in the timeout cycle takes priority over the error
                    if (csb2nvdla_write ? nvdla2csb_wr_complete : nvdla2csb_valid) begin
                        state  <= RESP;
                        pready <= 1'b1;
                        if (!csb2nvdla_write) prdata <= nvdla2csb_data;
                    end else if (tmo) begin
                        state     <= ERR;
                        pready    <= 1'b1;
                        pslverr   <= 1'b1;
                        err_count <= err_inc;
                    end
                end
                default: begin
                    state   <= IDLE;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb4_csb_bridge.sv
// tb_apb4_csb_bridge: table-driven check of two bridge instances (non-posted and posted writes,
// both with an 8-cycle timeout) plus hand sequences for reset, spurious responses and saturation.
module tb_apb4_csb_bridge;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic        cready = 1'b0, rvalid = 1'b0, wrc = 1'b0;
    logic [31:0] rdata = '0;

    logic [31:0] prdata [2];
    logic        pready [2];
    logic        pslverr [2];
    logic        cvalid [2];
    logic [15:0] caddr [2];
    logic [31:0] cwdat [2];
    logic        cwrite [2];
    logic        cnp [2];
    logic [7:0]  errc [2];

    apb4_csb_bridge #(.ADDR_W(32), .CSB_ADDR_W(16), .NPOSTED_WR(1'b1), .TIMEOUT_CYC(8)) dut0 (
        .csb_clk(clk), .csb_rstn(rstn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata[0]), .pready(pready[0]),
        .pslverr(pslverr[0]), .csb2nvdla_valid(cvalid[0]), .csb2nvdla_ready(cready),
        .csb2nvdla_addr(caddr[0]), .csb2nvdla_wdat(cwdat[0]), .csb2nvdla_write(cwrite[0]),
        .csb2nvdla_nposted(cnp[0]), .nvdla2csb_valid(rvalid), .nvdla2csb_data(rdata),
        .nvdla2csb_wr_complete(wrc), .err_count(errc[0]));

    apb4_csb_bridge #(.ADDR_W(32), .CSB_ADDR_W(16), .NPOSTED_WR(1'b0), .TIMEOUT_CYC(8)) dut1 (
        .csb_clk(clk), .csb_rstn(rstn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata[1]), .pready(pready[1]),
        .pslverr(pslverr[1]), .csb2nvdla_valid(cvalid[1]), .csb2nvdla_ready(cready),
        .csb2nvdla_addr(caddr[1]), .csb2nvdla_wdat(cwdat[1]), .csb2nvdla_write(cwrite[1]),
        .csb2nvdla_nposted(cnp[1]), .nvdla2csb_valid(rvalid), .nvdla2csb_data(rdata),
        .nvdla2csb_wr_complete(wrc), .err_count(errc[1]));

    typedef struct {
        bit          sel;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int          rdy;
        int          rsp;
        logic [31:0] rdata;
        int          lat;
        bit          err;
        bit          v;
        logic [15:0] addr;
        bit          np;
        logic [31:0] prd;
    } vec_t;

    vec_t V [12];

    int total = 0, bad = 0;
    int          o_lat;
    logic [31:0] o_rd, o_wd;
    logic        o_err, o_np, o_w, o_vnow;
    bit          o_sv;
    logic [15:0] o_va;
    logic [7:0]  o_ec, e0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // APB master plus a CSB responder: ready after rdy valid cycles, response rsp cycles after accept
    task automatic xfer(input vec_t v);
        int  s = int'(v.sel);
        bit  acc = 0, rdrv = 0;
        int  since = 0, vcnt = 0;
        o_lat = 0; o_rd = '0; o_err = 1'b0; o_sv = 0; o_va = '0; o_np = 1'b0; o_w = 1'b0;
        o_wd = '0; o_vnow = 1'b0; o_ec = '0;
        psel = 1'b1; penable = 1'b0; pwrite = v.w; paddr = v.a; pwdata = v.d; pstrb = v.s;
        @(negedge clk);
        penable = 1'b1;
        forever begin
            @(negedge clk);
            o_lat++;
            if (rdrv) begin acc = 1; since = 0; rdrv = 0; end
            if (acc) since++;
            rdata  = v.rdata;
            rvalid = acc && !v.w && since == v.rsp;
            wrc    = acc && v.w && since == v.rsp;
            if (pready[s]) begin
                o_rd = prdata[s]; o_err = pslverr[s]; o_vnow = cvalid[s]; o_ec = errc[s];
                break;
            end
            if (o_lat > 40) begin
                total++; bad++;
                $display("FAIL pready wait: no pready after %0d cycles", o_lat);
                break;
            end
            if (cvalid[s] && !o_sv) begin
                o_sv = 1; o_va = caddr[s]; o_np = cnp[s]; o_w = cwrite[s]; o_wd = cwdat[s];
            end
            if (cvalid[s]) vcnt++;
            rdrv = cvalid[s] && !acc && vcnt > v.rdy;
            cready = rdrv;
        end
        psel = 1'b0; penable = 1'b0; cready = 1'b0; rvalid = 1'b0; wrc = 1'b0;
    endtask

    initial begin
        vec_t ev;
        V[0]  = '{0, 0, 32'h0000_1004, 32'h0,         4'hF, 0,  1, 32'hCAFE_F00D, 3, 0, 1, 16'h0401, 0, 32'hCAFE_F00D};
        V[1]  = '{0, 1, 32'h0000_0020, 32'h1234_5678, 4'hF, 0,  5, 32'h0,         7, 0, 1, 16'h0008, 1, 32'h0};
        V[2]  = '{1, 1, 32'h0000_0040, 32'h1234_5678, 4'hF, 0, -1, 32'h0,         2, 0, 1, 16'h0010, 0, 32'h0};
        V[3]  = '{0, 0, 32'h0000_0002, 32'h0,         4'hF, 0,  1, 32'hDEAD_BEEF, 1, 1, 0, 16'h0,    0, 32'h0};
        V[4]  = '{0, 1, 32'h0000_0008, 32'hAAAA_5555, 4'h3, 0,  1, 32'h0,         1, 1, 0, 16'h0,    0, 32'h0};
        V[5]  = '{0, 0, 32'hABCD_FFFC, 32'h0,         4'hF, 3,  1, 32'h0BAD_BEEF, 6, 0, 1, 16'h7FFF, 0, 32'h0BAD_BEEF};
        V[6]  = '{0, 0, 32'h0000_0000, 32'h0,         4'hF, 0,  7, 32'h5A5A_A5A5, 9, 0, 1, 16'h0000, 0, 32'h5A5A_A5A5};
        V[7]  = '{0, 0, 32'h0000_0000, 32'h0,         4'hF, 0,  8, 32'h5A5A_A5A5, 9, 1, 1, 16'h0000, 0, 32'h0};
        V[8]  = '{0, 1, 32'h0000_0100, 32'h1111_2222, 4'hF, 99, 1, 32'h0,         9, 1, 1, 16'h0040, 1, 32'h0};
        V[9]  = '{0, 1, 32'h0000_0104, 32'h3333_4444, 4'hF, 0,  7, 32'h0,         9, 0, 1, 16'h0041, 1, 32'h0};
        V[10] = '{1, 1, 32'h0000_0200, 32'h5555_6666, 4'hF, 2, -1, 32'h0,         4, 0, 1, 16'h0080, 0, 32'h0};
        V[11] = '{0, 1, 32'h0000_0003, 32'h7777_8888, 4'hF, 0,  1, 32'h0,         1, 1, 0, 16'h0,    0, 32'h0};

        repeat (2) @(negedge clk);
        chk("reset state", {prdata[0], pready[0], pslverr[0], cvalid[0], caddr[0], cwdat[0],
                            cwrite[0], cnp[0], errc[0]}, '0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle after reset", {pready[0], pslverr[0], cvalid[0], pready[1], cvalid[1]}, '0);

        for (int i = 0; i < 12; i++) begin
            e0 = errc[V[i].sel];
            xfer(V[i]);
            chk($sformatf("v%0d latency", i), o_lat, V[i].lat);
            chk($sformatf("v%0d pslverr", i), o_err, V[i].err);
            chk($sformatf("v%0d prdata", i), o_rd, V[i].prd);
            chk($sformatf("v%0d err_count delta", i), 8'(o_ec - e0), V[i].err ? 8'd1 : 8'd0);
            chk($sformatf("v%0d csb valid seen", i), o_sv, V[i].v);
            chk($sformatf("v%0d valid at pready", i), o_vnow, 1'b0);
            if (V[i].v) begin
                chk($sformatf("v%0d csb addr", i), o_va, V[i].addr);
                chk($sformatf("v%0d csb nposted", i), o_np, V[i].np);
                chk($sformatf("v%0d csb write", i), o_w, V[i].w);
                chk($sformatf("v%0d csb wdat", i), o_wd, V[i].d);
            end
            repeat (12) @(negedge clk);
        end

        // late ready/data/wr_complete while idle must not produce a response
        cready = 1'b1; rvalid = 1'b1; wrc = 1'b1; rdata = 32'hFFFF_FFFF;
        repeat (3) begin
            @(negedge clk);
            chk("spurious idle", {pready[0], pslverr[0], cvalid[0]}, '0);
        end
        cready = 1'b0; rvalid = 1'b0; wrc = 1'b0;

        // reset while a read sits in WAIT
        psel = 1'b1; pwrite = 1'b0; paddr = 32'h0000_0FF0; pwdata = 32'h9999_9999; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        chk("req valid before reset", cvalid[0], 1'b1);
        cready = 1'b1;
        @(negedge clk);
        cready = 1'b0;
        chk("wait state before reset", {cvalid[0], pready[0], caddr[0]}, {1'b0, 1'b0, 16'h03FC});
        #2 rstn = 1'b0;
        #1 chk("async reset in wait", {prdata[0], pready[0], pslverr[0], cvalid[0], caddr[0],
                                       cwdat[0], cwrite[0], cnp[0], errc[0]}, '0);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        rvalid = 1'b1; rdata = 32'h1234_0000;
        repeat (3) begin
            @(negedge clk);
            chk("late data after reset", {pready[0], pslverr[0], prdata[0]}, '0);
        end
        rvalid = 1'b0;

        // error counter saturation
        ev = V[3];
        repeat (255) begin
            xfer(ev);
            @(negedge clk);
        end
        chk("err_count at 255", errc[0], 8'd255);
        repeat (2) begin
            xfer(ev);
            @(negedge clk);
        end
        chk("err_count saturated", errc[0], 8'd255);
        chk("error still reported", o_err, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
